boot_image_loader: RTL and testbench
====================================

Name: boot_image_loader

Overview:
- Upstream of the CPU and its byte-addressed RAM.
- Accepts a program image as a byte stream over a valid/ready handshake and writes the bytes into RAM at ascending addresses starting at 0.
- Emits each assembled 32-bit big-endian instruction word for tracing.
- Holds the CPU in reset until the image is complete, then releases it.

Parameters:
- ADDR_W, 8, RAM byte-address width.
- MEM_BYTES, 256, RAM capacity in bytes. Must be at most 2^ADDR_W and a multiple of 4.
- HOLD_CYCLES, 4, number of cycles cpu_rst_n stays low after the last byte is written. Must be at least 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins or restarts a load.
- byte_in  in  8  image byte.
- byte_valid  in  1  byte_in (and byte_last) are valid.
- byte_last  in  1  qualifies byte_in as the final image byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- ram_we  out  1  RAM byte write strobe.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- word_valid  out  1  one-cycle pulse; word_out is valid.
- word_out  out  32  assembled word, first byte in bits [31:24].
- byte_count  out  ADDR_W+1  number of bytes written in the current load.
- cpu_rst_n  out  1  active-low reset to the CPU.
- done  out  1  image loaded and CPU released.
- err  out  1  image overflowed RAM.

Behaviour:
- Reset (clr low, asynchronous) clears everything:
  - state IDLE.
  - byte_ready, ram_we, word_valid, done, err = 0.
  - cpu_rst_n = 0.
  - ram_addr, ram_wdata, word_out, byte_count, internal address, hold counter = 0.
- Reset mid-load abandons the load. Bytes already written stay in RAM, and the CPU remains held in reset.
- A transfer occurs when byte_valid and byte_ready are both high on a rising edge. byte_ready is a registered state decode: 1 only in LOAD.
- States:
  - IDLE: byte_ready=0, cpu_rst_n=0. On start: internal address=0, byte_count=0, go to LOAD.
  - LOAD: byte_ready=1.
    - Each transfer performs a write with 1-cycle latency: next cycle ram_we=1, ram_addr=the address the byte was accepted at, ram_wdata=byte_in.
    - The internal address and byte_count increment on the same transfer edge.
    - ram_we is a one-cycle pulse per transfer, so back-to-back transfers give back-to-back writes.
    - Gaps in byte_valid insert no writes.
  - RELEASE: byte_ready=0, cpu_rst_n=0. The hold counter counts HOLD_CYCLES cycles, then: cpu_rst_n=1, done=1, go to RUN.
  - RUN: cpu_rst_n=1, done=1, byte_ready=0. On start: cpu_rst_n=0 and done=0 on the next edge, address and byte_count cleared, go to LOAD (re-flash).
  - ERROR: err=1, cpu_rst_n=0, byte_ready=0. On start: err cleared, address and byte_count cleared, go to LOAD.
- start is ignored in LOAD and RELEASE.
- Word assembly:
  - Bytes shift into a 32-bit register in arrival order.
  - When the accepted byte has address[1:0]==3, word_valid pulses in the same cycle as that byte's ram_we. word_out = {byte a-3, a-2, a-1, a}.
  - If byte_last arrives with address[1:0]!=3, the partial word is still emitted. Missing low-order bytes are 0x00. Pad bytes are not written to RAM and not counted.
  - word_out holds its value between pulses.
- End of image: a transfer with byte_last=1 leads to RELEASE after its write. The write and any word_valid are still issued on the following cycle.
- Overflow:
  - A transfer at address MEM_BYTES-1 with byte_last=0 still writes that byte and leads to ERROR. byte_count = MEM_BYTES.
  - The address never wraps to 0 within a load.
- byte_last at address MEM_BYTES-1 is a legal full image and leads to RELEASE, not ERROR.
- A zero-length image is impossible: the first byte is the earliest possible byte_last.

Test Plan:
- 8-byte image E3A01004 E2811008 streamed back-to-back:
  - ram_we at addresses 0..7 on consecutive cycles.
  - word_valid twice: 0xE3A01004, then 0xE2811008.
  - byte_count=8.
  - cpu_rst_n rises exactly HOLD_CYCLES cycles after the last write cycle, together with done=1.
- 6-byte image 01 02 03 04 05 06 with byte_valid toggling every other cycle:
  - Exactly 6 writes, with no writes in the gap cycles.
  - Words 0x01020304 and 0x05060000.
  - byte_count=6.
- 257 bytes, byte_last never set, MEM_BYTES=256:
  - 256 writes (addresses 0..255), no wrap.
  - err=1, cpu_rst_n stays 0, byte_ready=0.
  - A subsequent start clears err and accepts a byte at address 0.
- 256 bytes with byte_last on byte 255: done=1, err=0.
- Assert clr low after 5 bytes of an 8-byte load:
  - All outputs at reset values immediately, with no clock edge needed.
  - After clr rises, the loader stays in IDLE until start.
- Load 4 bytes to RUN, then pulse start:
  - cpu_rst_n and done drop on the next edge.
  - A new 4-byte image writes from address 0.
  - The CPU is re-released after HOLD_CYCLES.
- A start pulse during LOAD is ignored.

Source files
------------

// File: rtl/boot_image_loader.sv
// boot_image_loader: streams a program image from a valid/ready byte
// interface into byte-addressed RAM, emits each assembled big-endian
// instruction word for tracing, and keeps the CPU in reset until the
// whole image has been written.
module boot_image_loader #(
  parameter int ADDR_W      = 8,
  parameter int MEM_BYTES   = 256,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              word_valid,
  output logic [31:0]       word_out,
  output logic [ADDR_W:0]   byte_count,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  // Wide enough to count 0..HOLD_CYCLES with headroom.
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1) + 1;

  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  // Builds the traced word from the bytes already seen in this word
  // (prev, oldest in the high byte) and the byte just accepted at word
  // position pos; positions not yet filled are padded with 0x00.
  function automatic logic [31:0] align_word(input logic [23:0] prev,
                                             input logic [7:0]  b,
                                             input logic [1:0]  pos);
    logic [31:0] w;
    case (pos)
      2'd0:    w = {b, 24'h000000};
      2'd1:    w = {prev[7:0], b, 16'h0000};
      2'd2:    w = {prev[15:0], b, 8'h00};
      default: w = {prev, b};
    endcase
    return w;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [23:0]       shift_q, shift_d;

  logic              byte_ready_q, byte_ready_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              word_valid_q, word_valid_d;
  logic [31:0]       word_out_q, word_out_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;

  // byte_ready_q mirrors the LOAD state, so it alone qualifies a transfer.
  assign xfer = byte_valid & byte_ready_q;

  // Next-state, write-path and word-assembly logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    word_valid_d = 1'b0;
    word_out_d   = word_out_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
        end else begin
          state_d = state_q;
        end
      end

      S_LOAD: begin
        hold_d = '0;
        if (xfer) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = byte_in;
          count_d     = count_q + CNT_ONE;
          shift_d     = {shift_q[15:0], byte_in};
          if ((addr_q[1:0] == 2'd3) || byte_last) begin
            word_valid_d = 1'b1;
            word_out_d   = align_word(shift_q, byte_in, addr_q[1:0]);
          end else begin
            word_valid_d = 1'b0;
          end
          // The address saturates at the top of RAM; a transfer there
          // always leaves LOAD, so it can never wrap back to 0.
          if (addr_q == LAST_ADDR) begin
            addr_d = addr_q;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
          if (byte_last) begin
            state_d = S_RELEASE;
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      // The first RELEASE cycle carries the final write; the CPU is then
      // held for HOLD_CYCLES further cycles before release.
      S_RELEASE: begin
        if (hold_q == HOLD_END) begin
          state_d = S_RUN;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HOLD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered decodes of the next state so they
    // line up exactly with the state register.
    byte_ready_d = (state_d == S_LOAD);
    cpu_rst_n_d  = (state_d == S_RUN);
    done_d       = (state_d == S_RUN);
    err_d        = (state_d == S_ERROR);
  end

  // Control state: FSM, load address, byte counter, hold timer, word shifter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
    end
  end

  // Registered outputs toward RAM, trace port and CPU.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      byte_ready_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      byte_ready_q <= byte_ready_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      word_valid_q <= word_valid_d;
      word_out_q   <= word_out_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign word_valid = word_valid_q;
  assign word_out   = word_out_q;
  assign byte_count = count_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Self-checking bench for boot_image_loader: random and directed images are
// streamed in, and the observed RAM writes, trace words and CPU-release
// timing are compared against a list-based model of the image.
module tb_boot_image_loader;

  localparam int ADDR_W      = 8;
  localparam int MEM_BYTES   = 256;
  localparam int HOLD_CYCLES = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              word_valid;
  logic [31:0]       word_out;
  logic [ADDR_W:0]   byte_count;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  boot_image_loader #(
    .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .word_valid(word_valid), .word_out(word_out), .byte_count(byte_count),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge it holds the index of the last rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed activity; only ever appended to, scenarios remember base indices.
  int          wr_addr_q[$];
  int          wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] wd_val_q[$];
  int          wd_cyc_q[$];
  int          rise_q[$];
  bit          prev_cpu = 1'b0;

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr_q.push_back(int'(ram_addr));
      wr_data_q.push_back(int'(ram_wdata));
      wr_cyc_q.push_back(cyc);
    end
    if (word_valid) begin
      wd_val_q.push_back(word_out);
      wd_cyc_q.push_back(cyc);
    end
    if (cpu_rst_n && !prev_cpu) rise_q.push_back(cyc);
    prev_cpu <= cpu_rst_n;
  end

  // Stimulus image and the edge at which each byte was accepted.
  logic [7:0] img[$];
  int         acc_q[$];

  task automatic fill_random(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // Streams img[0..n-1]; gap_mode 0 = back-to-back, 1 = valid every other
  // cycle, 2 = random gaps. poke_start raises start mid-load.
  task automatic send_bytes(input int n, input bit set_last, input int gap_mode,
                            input bit poke_start, input int budget, output int got);
    int i = 0;
    int t = 0;
    bit pend = 1'b0;
    acc_q.delete();
    while (i < n && t < budget) begin
      @(negedge clk);
      t++;
      if (pend) begin
        acc_q.push_back(cyc);
        i++;
      end
      start = 1'b0;
      if (i < n) begin
        case (gap_mode)
          0:       byte_valid = 1'b1;
          1:       byte_valid = (t % 2 == 1);
          default: byte_valid = ($urandom_range(0, 3) != 0);
        endcase
        byte_in   = img[i];
        byte_last = set_last && (i == n - 1);
        if (poke_start && i == n / 2) start = 1'b1;
      end else begin
        byte_valid = 1'b0;
        byte_last  = 1'b0;
      end
      pend = byte_valid && byte_ready;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    start      = 1'b0;
    got = i;
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".cpu_rst_n"}, cpu_rst_n, 1'b0);
    check_eq({tag, ".done"}, done, 1'b0);
    check_eq({tag, ".err"}, err, 1'b0);
    check_eq({tag, ".ready"}, byte_ready, 1'b1);
    check_eq({tag, ".count"}, byte_count, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".ready"}, byte_ready, 1'b0);
    check_eq({tag, ".we"}, ram_we, 1'b0);
    check_eq({tag, ".wv"}, word_valid, 1'b0);
    check_eq({tag, ".done"}, done, 1'b0);
    check_eq({tag, ".err"}, err, 1'b0);
    check_eq({tag, ".cpu"}, cpu_rst_n, 1'b0);
    check_eq({tag, ".addr"}, ram_addr, 0);
    check_eq({tag, ".wdata"}, ram_wdata, 0);
    check_eq({tag, ".word"}, word_out, 0);
    check_eq({tag, ".count"}, byte_count, 0);
  endtask

  // Reference model: k bytes land at addresses 0..k-1 one edge after their
  // acceptance; words are consecutive groups of four bytes (a short final
  // group only when the image ended with byte_last, zero padded), each
  // reported with the write of its last present byte.
  task automatic verify(input string tag, input int k, input bit last,
                        input int bw, input int bd, input int br);
    int nw;
    int idx;
    int lastb;
    logic [31:0] exp_w;
    check_eq({tag, ".nwr"}, wr_addr_q.size() - bw, k);
    for (int a = 0; a < k; a++) begin
      if (bw + a < wr_addr_q.size() && a < acc_q.size()) begin
        check_eq({tag, ".wa"}, wr_addr_q[bw + a], a);
        check_eq({tag, ".wd"}, wr_data_q[bw + a], img[a]);
        check_eq({tag, ".wcyc"}, wr_cyc_q[bw + a], acc_q[a]);
      end
    end
    nw = last ? (k + 3) / 4 : k / 4;
    check_eq({tag, ".nwords"}, wd_val_q.size() - bd, nw);
    for (int w = 0; w < nw; w++) begin
      exp_w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * w + j;
        exp_w = {exp_w[23:0], (idx < k) ? img[idx] : 8'h00};
      end
      lastb = (4 * w + 3 < k) ? 4 * w + 3 : k - 1;
      if (bd + w < wd_val_q.size() && lastb < acc_q.size()) begin
        check_eq({tag, ".word"}, wd_val_q[bd + w], exp_w);
        check_eq({tag, ".wordcyc"}, wd_cyc_q[bd + w], acc_q[lastb]);
      end
    end
    check_eq({tag, ".count"}, byte_count, k);
    if (last) begin
      check_eq({tag, ".done"}, done, 1'b1);
      check_eq({tag, ".err"}, err, 1'b0);
      check_eq({tag, ".cpu"}, cpu_rst_n, 1'b1);
      check_eq({tag, ".nrise"}, rise_q.size() - br, 1);
      // Last write cycle, then HOLD_CYCLES low cycles, then release.
      if (rise_q.size() > br && k > 0 && k <= acc_q.size())
        check_eq({tag, ".hold"}, rise_q[br] - acc_q[k - 1], HOLD_CYCLES + 1);
    end else begin
      check_eq({tag, ".err"}, err, 1'b1);
      check_eq({tag, ".done"}, done, 1'b0);
      check_eq({tag, ".cpu"}, cpu_rst_n, 1'b0);
      check_eq({tag, ".ready"}, byte_ready, 1'b0);
      check_eq({tag, ".nrise"}, rise_q.size() - br, 0);
    end
  endtask

  task automatic run_image(input string tag, input int n, input bit last,
                           input int gap_mode, input bit poke);
    int bw = wr_addr_q.size();
    int bd = wd_val_q.size();
    int br = rise_q.size();
    int got;
    int k;
    int t = 0;
    k = (n > MEM_BYTES) ? MEM_BYTES : n;
    send_bytes(n, last, gap_mode, poke, 8 * n + 50, got);
    check_eq({tag, ".accepted"}, got, k);
    if (last) begin
      while (done !== 1'b1 && t < HOLD_CYCLES + 20) begin
        @(negedge clk);
        t++;
      end
      check_eq({tag, ".done_wait"}, done, 1'b1);
    end else begin
      repeat (4) @(negedge clk);
    end
    #2;
    verify(tag, k, last, bw, bd, br);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    logic [7:0] plan8[8];
    plan8 = '{8'hE3, 8'hA0, 8'h10, 8'h04, 8'hE2, 8'h81, 8'h10, 8'h08};

    clr = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
    #2;
    check_reset_vals("por");
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle.ready", byte_ready, 1'b0);

    // Directed 8-byte image, back-to-back.
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(plan8[i]);
    pulse_start("start0");
    run_image("img8", 8, 1'b1, 0, 1'b0);

    // Re-flash from RUN with a 6-byte image and valid on alternate cycles.
    img.delete();
    for (int i = 1; i <= 6; i++) img.push_back(8'(i));
    pulse_start("reflash6");
    run_image("img6", 6, 1'b1, 1, 1'b0);

    // Random images with random gaps; start is poked mid-load and must be ignored.
    for (int r = 0; r < 6; r++) begin
      fill_random((r == 0) ? 4 : int'($urandom_range(1, 40)));
      pulse_start("reflash_rnd");
      run_image("rnd", img.size(), 1'b1, 2, (r % 2 == 0));
    end

    // Overflow: 257 bytes without byte_last.
    fill_random(257);
    pulse_start("ovf_start");
    run_image("ovf", 257, 1'b0, 0, 1'b0);

    // Recovery from ERROR with a one-byte image.
    fill_random(1);
    pulse_start("err_restart");
    run_image("one", 1, 1'b1, 0, 1'b0);

    // Full RAM image ending exactly at the top address.
    fill_random(256);
    pulse_start("full_start");
    run_image("full", 256, 1'b1, 2, 1'b0);

    // Abort an 8-byte load after 5 bytes with an asynchronous reset.
    fill_random(8);
    pulse_start("abort_start");
    send_bytes(5, 1'b0, 0, 1'b0, 100, got);
    check_eq("abort.accepted", got, 5);
    #2;
    clr = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    clr = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("abort_idle.ready", byte_ready, 1'b0);
    check_eq("abort_idle.cpu", cpu_rst_n, 1'b0);

    fill_random(4);
    pulse_start("after_abort");
    run_image("after_abort", 4, 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
